regs_seq: RTL and testbench

REGS_SEQ -- requirements
Module: regs_seq

---
 rtl/regs_seq_if.sv | 44 ++++
 rtl/regs_seq.sv | 201 ++++++++++++++++++++
 tb/tb_regs_seq.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regs_seq_if.sv
// Bus bundle for regs_seq: instruction handshake, register-file ports,
// ALU request/ack channel and status outputs.
interface regs_seq_if;
    logic       main_enable;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic [1:0] rf_raddr_a;
    logic [1:0] rf_raddr_b;
    logic [7:0] rf_rdata_a;
    logic [7:0] rf_rdata_b;
    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       alu_req;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_func;
    logic       alu_ack;
    logic [7:0] alu_result;
    logic       busy;
    logic       done;
    logic       err_illegal;
    logic       err_timeout;
    logic [7:0] instr_count;

    // controller side
    modport slave (
        input  main_enable, instr_valid, instr, rf_rdata_a, rf_rdata_b,
               alu_ack, alu_result,
        output instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               alu_req, alu_a, alu_b, alu_func, busy, done, err_illegal,
               err_timeout, instr_count
    );

    // environment side: instruction source, register file and ALU
    modport master (
        output main_enable, instr_valid, instr, rf_rdata_a, rf_rdata_b,
               alu_ack, alu_result,
        input  instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               alu_req, alu_a, alu_b, alu_func, busy, done, err_illegal,
               err_timeout, instr_count
    );
endinterface

// File: rtl/regs_seq.sv
// Four-state instruction sequencer: fetches 8-bit instructions, reads a
// 4-entry register file, hands ALU ops to an external ALU and writes back.
//
// state  | meaning
// IDLE   | waiting for an accepted instruction
// DECODE | register-file read, operands/write data latched
// EXEC   | ALU request outstanding, timeout down-counter running
// WB     | one-cycle register-file write and retire pulse
module regs_seq #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    regs_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_MOV = 2'b01;
    localparam logic [1:0] OP_ILL = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TCNT_LOAD = TW'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_state_nxt;

    logic [7:0]    r_ir;
    logic [1:0]    r_waddr;
    logic [7:0]    r_wdata;
    logic          r_alu_req;
    logic [7:0]    r_alu_a;
    logic [7:0]    r_alu_b;
    logic [1:0]    r_alu_func;
    logic          r_err_illegal;
    logic          r_err_timeout;
    logic [7:0]    r_count;
    logic [TW-1:0] r_tcnt;

    logic [1:0]    w_op;
    logic [1:0]    w_rd;
    logic [1:0]    w_rs;
    logic [3:0]    w_imm;
    logic [1:0]    w_func;
    logic          w_ready;
    logic          w_accept;
    logic          w_tc;
    logic [1:0]    w_raddr_a;
    logic [1:0]    w_raddr_b;
    logic          w_we;
    logic          w_done;

    assign w_op   = r_ir[7:6];
    assign w_rd   = r_ir[5:4];
    assign w_rs   = r_ir[3:2];
    assign w_imm  = r_ir[3:0];
    assign w_func = r_ir[1:0];

    // rst_n gates ready so it reads 0 while reset is held, not just after
    assign w_ready  = rst_n & (r_state == S_IDLE) & bus.main_enable;
    assign w_accept = w_ready & bus.instr_valid;
    assign w_tc     = (r_tcnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_raddr_a   = 2'd0;
        w_raddr_b   = 2'd0;
        w_we        = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_op)
                    OP_LDI: w_state_nxt = S_WB;
                    OP_MOV: begin
                        w_raddr_a   = w_rs;
                        w_state_nxt = S_WB;
                    end
                    OP_ALU: begin
                        w_raddr_a   = w_rd;
                        w_raddr_b   = w_rs;
                        w_state_nxt = S_EXEC;
                    end
                    default: begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                endcase
            end
            S_EXEC: begin
                // ack in the terminal cycle still completes normally
                if (bus.alu_ack) begin
                    w_state_nxt = S_WB;
                end else if (w_tc) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WB: begin
                w_we        = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir          <= 8'd0;
            r_waddr       <= 2'd0;
            r_wdata       <= 8'd0;
            r_alu_req     <= 1'b0;
            r_alu_a       <= 8'd0;
            r_alu_b       <= 8'd0;
            r_alu_func    <= 2'd0;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
            r_count       <= 8'd0;
            r_tcnt        <= '0;
        end else begin
            if (w_accept) begin
                r_ir <= bus.instr;
            end
            case (r_state)
                S_DECODE: begin
                    case (w_op)
                        OP_LDI: begin
                            r_waddr <= w_rd;
                            r_wdata <= {4'd0, w_imm};
                        end
                        OP_MOV: begin
                            r_waddr <= w_rd;
                            r_wdata <= bus.rf_rdata_a;
                        end
                        OP_ALU: begin
                            r_waddr    <= w_rd;
                            r_alu_a    <= bus.rf_rdata_a;
                            r_alu_b    <= bus.rf_rdata_b;
                            r_alu_func <= w_func;
                            r_alu_req  <= 1'b1;
                            r_tcnt     <= TCNT_LOAD;
                        end
                        OP_ILL: r_err_illegal <= 1'b1;
                        default: ;
                    endcase
                end
                S_EXEC: begin
                    if (bus.alu_ack) begin
                        r_wdata   <= bus.alu_result;
                        r_alu_req <= 1'b0;
                    end else if (w_tc) begin
                        r_alu_req     <= 1'b0;
                        r_err_timeout <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt - 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_done) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign bus.instr_ready = w_ready;
    assign bus.rf_raddr_a  = w_raddr_a;
    assign bus.rf_raddr_b  = w_raddr_b;
    assign bus.rf_we       = w_we;
    assign bus.rf_waddr    = r_waddr;
    assign bus.rf_wdata    = r_wdata;
    assign bus.alu_req     = r_alu_req;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_func    = r_alu_func;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = w_done;
    assign bus.err_illegal = r_err_illegal;
    assign bus.err_timeout = r_err_timeout;
    assign bus.instr_count = r_count;

endmodule

// File: tb/tb_regs_seq.sv
// Self-checking bench for regs_seq: random instruction stream against a
// behavioural model of the register file, retire count and error flags.
module tb_regs_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regs_seq_if bus();

    regs_seq #(.TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // environment register file, written from the DUT's write port
    logic [7:0] env_rf [4];
    assign bus.rf_rdata_a = env_rf[bus.rf_raddr_a];
    assign bus.rf_rdata_b = env_rf[bus.rf_raddr_b];

    // reference model state
    logic [7:0] mdl_rf [4];
    logic [7:0] mdl_cnt;
    logic       mdl_ill;
    logic       mdl_tmo;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] alu_op(input logic [1:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [63:0] all_outs();
        return {bus.instr_ready, bus.busy, bus.done, bus.rf_we, bus.rf_waddr,
                bus.rf_wdata, bus.alu_req, bus.alu_a, bus.alu_b, bus.alu_func,
                bus.err_illegal, bus.err_timeout, bus.instr_count,
                bus.rf_raddr_a, bus.rf_raddr_b};
    endfunction

    // d = EXEC cycle index (0-based) in which ack is raised; d >= 16 never acks
    task automatic run_instr(input logic [7:0] ins, input int d, input bit drop_en);
        logic [1:0] op;
        bit         e_we, e_done, e_alu, fin, unstable;
        logic [1:0] e_waddr;
        logic [7:0] e_wdata, e_a, e_b;
        int         e_wec, e_donec, e_reqs;
        int         n_we, n_done, we_c, done_c, reqs;
        logic [1:0] g_waddr, g_f;
        logic [7:0] g_wdata, g_a, g_b;

        op = ins[7:6];
        e_we = 0; e_done = 0; e_alu = 0; e_waddr = 0; e_wdata = 0;
        e_a = 0; e_b = 0; e_wec = 0; e_donec = 0; e_reqs = 0;
        case (op)
            2'b11: begin
                e_we = 1; e_done = 1; e_waddr = ins[5:4];
                e_wdata = {4'h0, ins[3:0]}; e_wec = 2; e_donec = 2;
            end
            2'b01: begin
                e_we = 1; e_done = 1; e_waddr = ins[5:4];
                e_wdata = mdl_rf[ins[3:2]]; e_wec = 2; e_donec = 2;
            end
            2'b00: begin
                e_alu = 1;
                e_a = mdl_rf[ins[5:4]];
                e_b = mdl_rf[ins[3:2]];
                if (d < 16) begin
                    e_we = 1; e_done = 1; e_waddr = ins[5:4];
                    e_wdata = alu_op(ins[1:0], e_a, e_b);
                    e_wec = d + 3; e_donec = d + 3; e_reqs = d + 1;
                end else begin
                    e_reqs = 16;
                    mdl_tmo = 1;
                end
            end
            default: begin
                e_done = 1; e_donec = 1; mdl_ill = 1;
            end
        endcase

        @(negedge clk);
        bus.main_enable = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        bus.alu_ack     = 1'b0;
        #1;
        check("ready_before_accept", bus.instr_ready, 1);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr       = 8'($urandom);
        if (drop_en) bus.main_enable = 1'b0;

        n_we = 0; n_done = 0; we_c = 0; done_c = 0; reqs = 0; fin = 0; unstable = 0;
        g_waddr = 0; g_wdata = 0; g_a = 0; g_b = 0; g_f = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1 && !bus.busy) begin
                fin = 1;
                break;
            end
            if (bus.rf_we) begin
                n_we++; we_c = c;
                g_waddr = bus.rf_waddr; g_wdata = bus.rf_wdata;
                env_rf[bus.rf_waddr] = bus.rf_wdata;
            end
            if (bus.done) begin
                n_done++; done_c = c;
            end
            if (bus.alu_req) begin
                if (reqs == 0) begin
                    g_a = bus.alu_a; g_b = bus.alu_b; g_f = bus.alu_func;
                end else if (g_a !== bus.alu_a || g_b !== bus.alu_b || g_f !== bus.alu_func) begin
                    unstable = 1;
                end
                bus.alu_ack    = (reqs == d);
                bus.alu_result = alu_op(bus.alu_func, bus.alu_a, bus.alu_b);
                reqs++;
            end else begin
                bus.alu_ack    = 1'($urandom);
                bus.alu_result = 8'($urandom);
            end
            @(negedge clk);
        end
        bus.alu_ack     = 1'b0;
        bus.main_enable = 1'b1;
        #1;

        check("finished", fin, 1);
        check("we_count", n_we, e_we ? 1 : 0);
        if (e_we) begin
            check("we_cycle", we_c, e_wec);
            check("waddr", g_waddr, e_waddr);
            check("wdata", g_wdata, e_wdata);
            mdl_rf[e_waddr] = e_wdata;
        end
        check("done_count", n_done, e_done ? 1 : 0);
        if (e_done) begin
            check("done_cycle", done_c, e_donec);
            mdl_cnt = mdl_cnt + 8'd1;
        end
        check("req_cycles", reqs, e_reqs);
        if (e_alu) begin
            check("alu_a", g_a, e_a);
            check("alu_b", g_b, e_b);
            check("alu_func", g_f, ins[1:0]);
            check("alu_stable", unstable, 0);
        end
        check("err_illegal", bus.err_illegal, mdl_ill);
        check("err_timeout", bus.err_timeout, mdl_tmo);
        check("instr_count", bus.instr_count, mdl_cnt);
        check("idle_ready", bus.instr_ready, 1);
        check("idle_raddr", {bus.rf_raddr_a, bus.rf_raddr_b}, 0);
    endtask

    task automatic reset_mid_exec();
        @(negedge clk);
        bus.main_enable = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr       = 8'h1B;
        bus.alu_ack     = 1'b0;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("rst_exec_req", bus.alu_req, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outs", all_outs(), 0);
        mdl_cnt = 0; mdl_ill = 0; mdl_tmo = 0;
        @(negedge clk);
        check("rst_held_outs", all_outs(), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", bus.instr_ready, 1);
        check("rst_release_busy", bus.busy, 0);
    endtask

    task automatic enable_off();
        bus.main_enable = 1'b0;
        bus.instr_valid = 1'b1;
        bus.instr       = 8'hC5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("en_off_ready", bus.instr_ready, 0);
            check("en_off_busy", bus.busy, 0);
        end
        bus.instr_valid = 1'b0;
        bus.main_enable = 1'b1;
        check("en_off_count", bus.instr_count, mdl_cnt);
    endtask

    function automatic logic [7:0] rand_instr(input bit allow_ill);
        logic [7:0] v;
        v = 8'($urandom);
        if (!allow_ill && v[7:6] == 2'b10) v[7:6] = 2'b11;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin
            env_rf[i] = 8'd0;
            mdl_rf[i] = 8'd0;
        end
        mdl_cnt = 0; mdl_ill = 0; mdl_tmo = 0;
        bus.main_enable = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 8'd0;
        bus.alu_ack     = 1'b0;
        bus.alu_result  = 8'd0;

        #3;
        check("reset_outs", all_outs(), 0);
        #19 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", bus.instr_ready, 1);

        run_instr(8'hC1, 0, 0);
        run_instr(8'hD3, 0, 0);
        run_instr(8'h04, 3, 0);
        run_instr(8'h18, 99, 0);
        run_instr(8'h80, 0, 0);
        run_instr(8'h9C, 15, 0);
        run_instr(8'h2D, 15, 1);
        run_instr(8'h54, 0, 1);

        for (int n = 0; n < 120; n++) begin
            run_instr(rand_instr(1), int'($urandom_range(0, 19)), 1'($urandom));
        end

        reset_mid_exec();
        enable_off();

        for (int n = 0; n < 256; n++) begin
            run_instr(rand_instr(1), int'($urandom_range(0, 10)), 1'($urandom));
        end
        check("count_wrap", bus.instr_count, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule
